morse_msg_sched: RTL and testbench

MORSE_MSG_SCHED -- requirements
Module: morse_msg_sched

---
 rtl/morse_msg_sched.sv | 169 ++++++++++++++++
 tb/tb_morse_msg_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_msg_sched.sv
// Message scheduler for a Morse letter datapath: queues letters and word spaces
// in a small FIFO and issues them one at a time with inter-letter and word gaps.
module morse_msg_sched #(
  parameter int DEPTH      = 4,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       push,
  input  logic       push_space,
  input  logic [2:0] letter,
  input  logic       flush,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [2:0] tx_letter,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXG = (WORD_GAP > LETTER_GAP) ? WORD_GAP : LETTER_GAP;
  localparam int GW   = $clog2(MAXG + 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [GW-1:0] LGAP    = GW'(LETTER_GAP);
  localparam logic [GW-1:0] WGAP    = GW'(WORD_GAP);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  logic [3:0]    fifo_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  state_t        state_r;
  state_t        state_s;
  logic [GW-1:0] gap_r;
  logic [GW-1:0] gap_s;
  logic          tx_start_r;
  logic          tx_start_s;
  logic [2:0]    tx_letter_r;
  logic [2:0]    tx_letter_s;
  logic          overflow_r;
  logic          full_s;
  logic          push_ok_s;
  logic          pop_s;
  logic [3:0]    head_s;

  // full comes only from the registered count, so a same-cycle pop never rescues a push
  assign full_s    = (count_r == DEPTH_C);
  assign push_ok_s = push && !full_s;
  assign head_s    = fifo_r[rd_ptr_r];

  // Next-state, pop decision and issue outputs of the sequencer
  always_comb begin
    state_s     = state_r;
    gap_s       = gap_r;
    tx_start_s  = 1'b0;
    tx_letter_s = tx_letter_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != {(AW + 1){1'b0}}) begin
          pop_s = 1'b1;
          if (head_s[3]) begin
            gap_s   = WGAP;
            state_s = GAP;
          end else begin
            tx_start_s  = 1'b1;
            tx_letter_s = head_s[2:0];
            state_s     = WAIT_ACK;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_s = WAIT_DONE;
        end else begin
          state_s = WAIT_ACK;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          gap_s   = LGAP;
          state_s = GAP;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_r <= GW'(1)) begin
            gap_s   = {GW{1'b0}};
            state_s = IDLE;
          end else begin
            gap_s = gap_r - GW'(1);
          end
        end else begin
          gap_s = gap_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Entry storage; contents need no reset since count guards every read
  always_ff @(posedge CLOCK_50) begin
    if (!reset && !flush && push_ok_s) begin
      fifo_r[wr_ptr_r] <= {push_space, push_space ? 3'b000 : letter};
    end
  end

  // Pointers, count, FSM and output registers; flush keeps overflow and tx_letter
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {(AW + 1){1'b0}};
      state_r     <= IDLE;
      gap_r       <= {GW{1'b0}};
      tx_start_r  <= 1'b0;
      tx_letter_r <= 3'd0;
      overflow_r  <= 1'b0;
    end else if (flush) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW + 1){1'b0}};
      state_r    <= IDLE;
      gap_r      <= {GW{1'b0}};
      tx_start_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      gap_r       <= gap_s;
      tx_start_r  <= tx_start_s;
      tx_letter_r <= tx_letter_s;
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
      if (push && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign tx_start  = tx_start_r;
  assign tx_letter = tx_letter_r;
  assign full      = full_s;
  assign busy      = (count_r != {(AW + 1){1'b0}}) || (state_r != IDLE);
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_morse_msg_sched.sv
// Directed bench for morse_msg_sched: a table of single-cycle vectors plus
// hand-written multi-cycle sequences against a simple downstream model.
module tb_morse_msg_sched;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       push;
  logic       push_space;
  logic [2:0] letter;
  logic       flush;
  logic       tx_busy;
  logic       tx_start;
  logic [2:0] tx_letter;
  logic       full;
  logic       busy;
  logic       overflow;

  logic tx_busy_m;
  logic hold_busy;
  int   n_checks;
  int   n_fail;
  int   tick_total;
  int   last_fall;
  int   starts[$];
  int   gaps[$];

  typedef struct {
    logic       push;
    logic       space;
    logic [2:0] letter;
    logic       flush;
    logic       exp_start;
    logic [2:0] exp_letter;
    logic       exp_full;
    logic       exp_busy;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[7];

  morse_msg_sched #(.DEPTH(4), .LETTER_GAP(3), .WORD_GAP(7)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .tick      (tick),
    .push      (push),
    .push_space(push_space),
    .letter    (letter),
    .flush     (flush),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_letter (tx_letter),
    .full      (full),
    .busy      (busy),
    .overflow  (overflow)
  );

  assign tx_busy = tx_busy_m | hold_busy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts ticks seen by the DUT at each rising edge
  always @(posedge clk) tick_total <= tick_total + (tick ? 1 : 0);

  // Tick every 3 cycles; downstream stays busy for 4 ticks after each start
  initial begin
    int phase;
    int left;
    phase = 0;
    left = 0;
    tick = 1'b0;
    tx_busy_m = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_busy_m && tick) begin
        left = left - 1;
        if (left == 0) tx_busy_m = 1'b0;
      end
      if (tx_start && !tx_busy_m) begin
        tx_busy_m = 1'b1;
        left = 4;
      end
      phase = (phase == 2) ? 0 : phase + 1;
      tick = (phase == 0);
    end
  end

  // Logs every issued letter and the ticks since the downstream last went idle
  initial begin
    logic prev;
    prev = 1'b0;
    last_fall = 0;
    forever begin
      @(posedge clk);
      #1;
      if (prev && !tx_busy) last_fall = tick_total;
      prev = tx_busy;
      if (tx_start) begin
        starts.push_back(int'(tx_letter));
        gaps.push_back(tick_total - last_fall);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (!busy && !tx_busy) break;
      step();
    end
    chk(nm, 32'(i < 2000), 32'd1);
  endtask

  task automatic push_one(input logic sp, input logic [2:0] l);
    push = 1'b1;
    push_space = sp;
    letter = l;
    step();
    push = 1'b0;
    push_space = 1'b0;
  endtask

  initial begin
    bit seen;
    int i;
    n_checks = 0;
    n_fail = 0;
    tick_total = 0;
    reset = 1'b1;
    push = 1'b0;
    push_space = 1'b0;
    letter = 3'd0;
    flush = 1'b0;
    hold_busy = 1'b0;

    // push, space, letter, flush | start, tx_letter, full, busy, overflow
    vecs[0] = '{1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b1};

    step();
    step();
    reset = 1'b0;
    chk("reset_outputs", {25'd0, tx_start, tx_letter, full, busy, overflow}, 32'd0);

    // Overflow: first letter parks the FSM in WAIT_DONE, then 5 pushes
    hold_busy = 1'b1;
    for (int v = 0; v < 7; v++) begin
      push = vecs[v].push;
      push_space = vecs[v].space;
      letter = vecs[v].letter;
      flush = vecs[v].flush;
      step();
      chk($sformatf("vec%0d", v),
          {25'd0, tx_start, tx_letter, full, busy, overflow},
          {25'd0, vecs[v].exp_start, vecs[v].exp_letter, vecs[v].exp_full,
           vecs[v].exp_busy, vecs[v].exp_ovf});
    end
    push = 1'b0;
    starts.delete();
    gaps.delete();
    hold_busy = 1'b0;
    wait_idle("ovf_drain_timeout");
    chk("ovf_issued_count", starts.size(), 32'd4);
    for (int k = 0; k < starts.size() && k < 4; k++)
      chk($sformatf("ovf_letter%0d", k), starts[k], k + 1);
    chk("ovf_sticky", overflow, 1'b1);

    // Single letter: latency and trailing letter gap
    starts.delete();
    gaps.delete();
    push_one(1'b0, 3'd0);
    chk("single_no_early_start", tx_start, 1'b0);
    step();
    chk("single_start", {tx_start, tx_letter}, {1'b1, 3'd0});
    step();
    chk("single_pulse_width", tx_start, 1'b0);
    wait_idle("single_timeout");
    chk("single_busy_fall_ticks", tick_total - last_fall, 32'd3);
    chk("single_count", starts.size(), 32'd1);

    // Ordering: three back-to-back pushes
    starts.delete();
    gaps.delete();
    push_one(1'b0, 3'd0);
    push_one(1'b0, 3'd1);
    push_one(1'b0, 3'd2);
    wait_idle("order_timeout");
    chk("order_count", starts.size(), 32'd3);
    if (starts.size() == 3) begin
      chk("order_l0", starts[0], 32'd0);
      chk("order_l1", starts[1], 32'd1);
      chk("order_l2", starts[2], 32'd2);
      chk("order_gap1", gaps[1], 32'd3);
      chk("order_gap2", gaps[2], 32'd3);
    end

    // Space: letter gap plus word gap before the next letter
    starts.delete();
    gaps.delete();
    push_one(1'b0, 3'd0);
    push_one(1'b1, 3'd5);
    push_one(1'b0, 3'd1);
    wait_idle("space_timeout");
    chk("space_count", starts.size(), 32'd2);
    if (starts.size() == 2) begin
      chk("space_l0", starts[0], 32'd0);
      chk("space_l1", starts[1], 32'd1);
      chk("space_gap", gaps[1], 32'd10);
    end

    // Flush while in GAP with two entries queued
    starts.delete();
    gaps.delete();
    push_one(1'b0, 3'd3);
    step();
    chk("flush_issue", {tx_start, tx_letter}, {1'b1, 3'd3});
    push_one(1'b0, 3'd4);
    push_one(1'b0, 3'd5);
    seen = 1'b0;
    for (i = 0; i < 200; i++) begin
      step();
      if (tx_busy) seen = 1'b1;
      else if (seen) break;
    end
    chk("flush_reach_gap", {seen, tx_busy}, 2'b10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_outputs", {28'd0, tx_start, busy, full, overflow}, 32'd1);
    chk("flush_letter_kept", tx_letter, 3'd3);
    repeat (60) step();
    chk("flush_no_start", starts.size(), 32'd1);
    wait_idle("flush_timeout");

    // Reset during WAIT_DONE, with a push in the same cycle
    starts.delete();
    gaps.delete();
    push_one(1'b0, 3'd6);
    push_one(1'b0, 3'd2);
    for (i = 0; i < 20; i++) begin
      if (tx_busy) break;
      step();
    end
    step();
    chk("reset_pre_busy", {tx_busy, busy, overflow}, 3'b111);
    reset = 1'b1;
    push = 1'b1;
    letter = 3'd5;
    step();
    reset = 1'b0;
    push = 1'b0;
    chk("reset_mid_outputs", {25'd0, tx_start, tx_letter, full, busy, overflow}, 32'd0);
    repeat (60) step();
    chk("reset_no_start", starts.size(), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
